ysyx_22041207_ifu_rbridge: RTL
==============================

YSYX_22041207_IFU_RBRIDGE -- requirements
Module: ysyx_22041207_ifu_rbridge

Interface
REQ-001 Parameter: none; all widths fixed as listed.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx_r_valid_i  input  1  fetch request valid from IF.
REQ-005 rx_r_ready_o  output  1  bridge can accept a fetch request.
REQ-006 rx_r_addr_i  input  64  fetch byte address.
REQ-007 rx_r_size_i  input  8  byte-lane mask from IF; carried for future use, no effect on the AXI request.
REQ-008 rx_data_read_o  output  64  returned aligned doubleword.
REQ-009 rx_data_valid  output  1  rx_data_read_o valid.
REQ-010 rx_data_ready  input  1  IF accepts data.
REQ-011 axi_arvalid  output  1 / axi_arready  input  1  AXI4 read-address handshake.
REQ-012 axi_araddr  output  64 / axi_arsize  output  3 / axi_arlen  output  8  AXI4 read-address payload.
REQ-013 axi_rvalid  input  1 / axi_rready  output  1 / axi_rdata  input  64 / axi_rresp  input  2 / axi_rlast  input  1  AXI4 read-data channel.
REQ-014 rd_err  output  1  one-cycle pulse on a non-OKAY or malformed response.
REQ-015 fetch_cnt  output  32  count of fetches delivered to IF.

Function
REQ-016 The FSM SHALL have four states: IDLE, AR, R, DATA; one request in flight at a time.
REQ-017 IDLE: rx_r_ready_o=1, all else low; on rx_r_valid_i=1, latch rx_r_addr_i and go to AR next cycle.
REQ-018 rx_r_ready_o SHALL be 0 in AR, R, DATA; requests there are neither accepted nor lost (IF holds valid).
REQ-019 AR: axi_arvalid=1; axi_araddr={addr[63:3],3'b000}; axi_arsize=3'b011; axi_arlen=0; payload stable while arvalid=1; on axi_arready=1 go to R.
REQ-020 R: axi_rready=1; on axi_rvalid=1 latch axi_rdata into rx_data_read_o and go to DATA.
REQ-021 R beat with axi_rresp!=2'b00 or axi_rlast=0: data still latched and delivered, rd_err=1 for exactly the following cycle.
REQ-022 DATA: rx_data_valid=1, rx_data_read_o stable; on rx_data_ready=1 go to IDLE, fetch_cnt+1.
REQ-023 fetch_cnt SHALL wrap 32'hFFFFFFFF -> 0 with no flag.
REQ-024 Minimum latency with arready, rvalid, rx_data_ready all held high: request accepted cycle 0, arvalid cycle 1, rready cycle 2, rx_data_valid cycle 3, back in IDLE cycle 4.
REQ-025 No request accepted in the DATA->IDLE transition cycle (no IDLE bypass); back-to-back fetches spaced 4 cycles.
REQ-026 rx_data_read_o SHALL hold its last value in IDLE/AR/R; only rx_data_valid qualifies it.
REQ-027 axi_arready while not in AR and axi_rvalid while not in R SHALL be ignored.

Reset
REQ-028 rst=1 SHALL force IDLE, rx_r_ready_o=1 on release, axi_arvalid=0, axi_rready=0, rx_data_valid=0, rd_err=0, fetch_cnt=0, rx_data_read_o=0, latched address=0, immediately and regardless of clk.
REQ-029 Reset mid-transaction SHALL abandon the outstanding AXI read without completion; the memory side is also reset by the same rst.

Verification
REQ-030 Single fetch: addr 64'h80000004, arready/rvalid/rx_data_ready=1, rdata 64'h00100073_00000413 -> araddr 64'h80000000, arsize 3, arlen 0, rx_data_valid cycle 3 with that rdata, fetch_cnt=1.
REQ-031 Back-pressure: arready low 3 cycles, rvalid low 2, rx_data_ready low 2 -> araddr/data stable throughout, exactly one delivery, rx_r_ready_o low until DATA accepted.
REQ-032 Error: rresp=2'b10 with rdata 64'hDEADBEEF_CAFEBABE -> data delivered, rd_err high one cycle, fetch_cnt still increments.
REQ-033 Reset in R: assert rst while rready=1 -> all outputs reset same cycle, later rvalid ignored, next request at 64'h80000008 completes normally.
REQ-034 Wrap: preload via 2^32 fetches or forced counter at 32'hFFFFFFFF -> one fetch yields fetch_cnt=0.
REQ-035 Spurious: rvalid=1 in IDLE and arready=1 in R -> no state change, no delivery.

Source files
------------

// File: rtl/ysyx_22041207_ifu_rbridge.sv
// Instruction-fetch read bridge: turns one IF fetch request into a single-beat
// AXI4 read of the enclosing aligned doubleword and hands the data back to IF.
module ysyx_22041207_ifu_rbridge (
  input  logic        clk,
  input  logic        rst,

  input  logic        rx_r_valid_i,
  output logic        rx_r_ready_o,
  input  logic [63:0] rx_r_addr_i,
  input  logic [7:0]  rx_r_size_i,
  output logic [63:0] rx_data_read_o,
  output logic        rx_data_valid,
  input  logic        rx_data_ready,

  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [63:0] axi_araddr,
  output logic [2:0]  axi_arsize,
  output logic [7:0]  axi_arlen,

  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [63:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,

  output logic        rd_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DATA
  } state_t;

  state_t      state;
  logic [60:0] addr_q;
  logic        size_unused;

  // Byte-lane mask is accepted on the interface but not yet used.
  assign size_unused = ^rx_r_size_i;

  // Only the doubleword index is kept; the request is always 8 bytes, 1 beat.
  assign axi_araddr = {addr_q, 3'b000};
  assign axi_arsize = 3'b011;
  assign axi_arlen  = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr_q         <= '0;
      rx_data_read_o <= '0;
      fetch_cnt      <= '0;
      rx_r_ready_o   <= 1'b1;
      axi_arvalid    <= 1'b0;
      axi_rready     <= 1'b0;
      rx_data_valid  <= 1'b0;
      rd_err         <= 1'b0;
    end else begin
      rd_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_r_valid_i) begin
            addr_q       <= rx_r_addr_i[63:3];
            rx_r_ready_o <= 1'b0;
            axi_arvalid  <= 1'b1;
            state        <= AR;
          end
        end
        AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= R;
          end
        end
        R: begin
          if (axi_rvalid) begin
            rx_data_read_o <= axi_rdata;
            // Bad responses are still delivered; the error is only flagged.
            rd_err         <= (axi_rresp != 2'b00) || !axi_rlast;
            axi_rready     <= 1'b0;
            rx_data_valid  <= 1'b1;
            state          <= DATA;
          end
        end
        DATA: begin
          if (rx_data_ready) begin
            rx_data_valid <= 1'b0;
            rx_r_ready_o  <= 1'b1;
            fetch_cnt     <= fetch_cnt + 32'd1;
            state         <= IDLE;
          end
        end
        default: begin
          rx_r_ready_o  <= 1'b1;
          axi_arvalid   <= 1'b0;
          axi_rready    <= 1'b0;
          rx_data_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
